// File: rtl/pika_sprite_reader_pkg.sv
// Shared defaults and FSM encoding for the sprite reader.
package pika_sprite_reader_pkg;
  localparam int SPRITE_W_DEF = 54;
  localparam int SPRITE_H_DEF = 58;
  localparam int COLOR_W_DEF  = 3;
  localparam int ADDR_W_DEF   = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/pika_pixel_skid.sv
// Two-entry FIFO holding returned pixels with their screen coordinates.
module pika_pixel_skid #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // Pointer, storage and occupancy next-state
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = ~rd_q;
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= {WIDTH{1'b0}};
      mem_q[1] <= {WIDTH{1'b0}};
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/pika_sprite_reader.sv
// Streams a sprite from memory in row-major order as screen-positioned pixels.
module pika_sprite_reader
  import pika_sprite_reader_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         base_x,
  input  logic [6:0]         base_y,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_x,
  output logic [6:0]         out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               busy,
  output logic               done
);
  localparam int CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW    = $clog2(SPRITE_H + 1);
  localparam int PIX_W = 15 + COLOR_W;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        bx_q, bx_d, pend_x_q, pend_x_d;
  logic [6:0]        by_q, by_d, pend_y_q, pend_y_d;
  logic              infl_q, infl_d;
  logic              buf_full, buf_empty, can_issue, issue, last_addr;
  logic [PIX_W-1:0]  buf_dout;

  // occupancy + in-flight < 2 reduces to these two cases
  assign can_issue = buf_empty | (~buf_full & ~infl_q);
  assign issue     = (state_q == ST_READ) & can_issue;
  assign last_addr = (col_q == CW'(SPRITE_W - 1)) & (row_q == RW'(SPRITE_H - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_READ : ST_IDLE;
      ST_READ:  state_d = (issue && last_addr) ? ST_DRAIN : ST_READ;
      ST_DRAIN: state_d = (buf_empty && !infl_q) ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rd = issue;
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DRAIN) & buf_empty & ~infl_q;
  end

  // Scan counters, latched bases and in-flight tag
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    bx_d     = bx_q;
    by_d     = by_q;
    infl_d   = issue;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    if ((state_q == ST_IDLE) && start) begin
      bx_d   = base_x;
      by_d   = base_y;
      col_d  = {CW{1'b0}};
      row_d  = {RW{1'b0}};
      addr_d = {ADDR_W{1'b0}};
    end else if (issue) begin
      pend_x_d = bx_q + 8'(col_q);
      pend_y_d = by_q + 7'(row_q);
      addr_d   = addr_q + ADDR_W'(1);
      if (col_q == CW'(SPRITE_W - 1)) begin
        col_d = {CW{1'b0}};
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q    <= {CW{1'b0}};
      row_q    <= {RW{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      bx_q     <= 8'd0;
      by_q     <= 7'd0;
      infl_q   <= 1'b0;
      pend_x_q <= 8'd0;
      pend_y_q <= 7'd0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      infl_q   <= infl_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
    end
  end

  assign mem_addr  = addr_q;
  assign out_valid = ~buf_empty;
  assign {out_x, out_y, out_color} = buf_dout;

  pika_pixel_skid #(.WIDTH(PIX_W)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (infl_q),
    .din     ({pend_x_q, pend_y_q, mem_data}),
    .pop     (out_valid & out_ready),
    .dout    (buf_dout),
    .full    (buf_full),
    .empty   (buf_empty)
  );
endmodule

// File: tb/tb_pika_sprite_reader.sv
// Randomised self-checking bench for pika_sprite_reader against a row-major pixel model.
module tb_pika_sprite_reader;
  localparam int W = 54;
  localparam int H = 58;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_x = 8'd0;
  logic [6:0]  base_y = 7'd0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [2:0]  mem_data = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_color;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  pika_sprite_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_x(base_x), .base_y(base_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Single-cycle sprite memory: colour is the low address bits
  always @(posedge clock) mem_data <= mem_addr[2:0];

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_rd, out_valid, busy, done, mem_addr, out_x, out_y, out_color} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0",
               {mem_rd, out_valid, busy, done, mem_addr, out_x, out_y, out_color});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Runs one sprite read and checks every handshake against the model
  task automatic run_read(input logic [7:0] bx, input logic [6:0] by, input bit rand_ready,
                          input int restart_at, input int abort_at, input string tag);
    int hs = 0, cyc = 0, rd = 0, last_cyc = -10, dones = 0, first_valid = -1;
    bit stall = 1'b0, finished = 1'b0, aborted = 1'b0, restarted = 1'b0;
    logic [7:0] sx, ex;
    logic [6:0] sy, ey;
    logic [2:0] sc, ec;
    int col, row;
    @(negedge clock);
    start = 1'b1; base_x = bx; base_y = by; out_ready = 1'b1;
    while (!finished && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart_at >= 0 && hs == restart_at && !restarted) begin
        start = 1'b1; base_x = 8'd0; base_y = 7'd0; restarted = 1'b1;
      end
      if (cyc == last_cyc + 1) begin
        start = 1'b1; base_x = 8'd0; base_y = 7'd0;
      end
      if (abort_at >= 0 && hs >= abort_at && out_valid) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd, out_valid, busy, done, mem_addr, out_x, out_y, out_color} !== 33'd0) begin
          errors++;
          $display("FAIL %s abort_outputs got %0h exp 0", tag,
                   {mem_rd, out_valid, busy, done, mem_addr, out_x, out_y, out_color});
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
          @(negedge clock);
          #1;
          checks++;
          if ({done, busy, out_valid, mem_rd} !== 4'd0) begin
            errors++;
            $display("FAIL %s post_abort got %b exp 0000", tag, {done, busy, out_valid, mem_rd});
          end
        end
        aborted = 1'b1;
        finished = 1'b1;
      end else begin
        #1;
        if (first_valid < 0 && out_valid) first_valid = cyc;
        checks++;
        if (done !== (cyc == last_cyc + 1)) begin
          errors++;
          $display("FAIL %s done cyc %0d got %b exp %b", tag, cyc, done, (cyc == last_cyc + 1));
        end
        if (done === 1'b1) dones++;
        if (cyc == last_cyc + 2) begin
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done got %b exp 0", tag, busy);
          end
          finished = 1'b1;
        end
        if (mem_rd) begin
          checks++;
          if (rd - hs >= 2) begin
            errors++;
            $display("FAIL %s rd_overcommit got %0d exp <2", tag, rd - hs);
          end
          rd++;
        end
        if (stall) begin
          checks++;
          if ({out_valid, out_x, out_y, out_color} !== {1'b1, sx, sy, sc}) begin
            errors++;
            $display("FAIL %s stall_hold got %0h exp %0h", tag,
                     {out_valid, out_x, out_y, out_color}, {1'b1, sx, sy, sc});
          end
        end
        if (out_valid && out_ready) begin
          col = hs % W;
          row = hs / W;
          ex  = 8'((int'(bx) + col) % 256);
          ey  = 7'((int'(by) + row) % 128);
          ec  = 3'((row * W + col) % 8);
          checks++;
          if (hs >= NPIX || {out_x, out_y, out_color} !== {ex, ey, ec}) begin
            errors++;
            $display("FAIL %s pixel %0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", tag, hs,
                     out_x, out_y, out_color, ex, ey, ec);
          end
          if (bx == 8'd240 && by == 7'd100 && hs == 30 * W + 20) begin
            checks++;
            if ({out_x, out_y} !== {8'd4, 7'd2}) begin
              errors++;
              $display("FAIL %s wrap_pixel got (%0d,%0d) exp (4,2)", tag, out_x, out_y);
            end
          end
          hs++;
          if (hs == NPIX) last_cyc = cyc;
        end
        stall = out_valid && !out_ready;
        sx = out_x; sy = out_y; sc = out_color;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      checks++;
      if (!finished || hs != NPIX || dones != 1) begin
        errors++;
        $display("FAIL %s completion got hs=%0d dones=%0d fin=%0d exp hs=%0d dones=1 fin=1",
                 tag, hs, dones, finished, NPIX);
      end
      checks++;
      if (first_valid != 3) begin
        errors++;
        $display("FAIL %s first_valid_latency got %0d exp 3", tag, first_valid);
      end
    end
  endtask

  task automatic test_basic();
    run_read(8'd10, 7'd20, 1'b0, -1, -1, "basic");
  endtask

  task automatic test_wrap();
    run_read(8'd240, 7'd100, 1'b0, -1, -1, "wrap");
  endtask

  task automatic test_random_ready();
    run_read(8'd10, 7'd20, 1'b1, -1, -1, "rand_ready");
  endtask

  task automatic test_restart_ignored();
    run_read(8'd10, 7'd20, 1'b1, 1000, -1, "restart");
  endtask

  task automatic test_abort();
    run_read(8'd10, 7'd20, 1'b1, -1, 500, "abort");
    run_read(8'd10, 7'd20, 1'b0, -1, -1, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random_ready();
    test_restart_ignored();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pika_sprite_reader.md
PIKA_SPRITE_READER -- requirements
Module: pika_sprite_reader

Interface
REQ-001 Parameter SPRITE_W, default 54: sprite width in pixels; column index 0..53.
REQ-002 Parameter SPRITE_H, default 58: sprite height in pixels; row index 0..57.
REQ-003 Parameter COLOR_W, default 3: pixel colour width.
REQ-004 Parameter ADDR_W, default 12: sprite memory address width; must satisfy SPRITE_W*SPRITE_H <= 2**ADDR_W.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request one full sprite read; honoured only in IDLE.
REQ-008 base_x  input  8  screen X of sprite column 0; latched on accepted start.
REQ-009 base_y  input  7  screen Y of sprite row 0; latched on accepted start.
REQ-010 mem_rd  output  1  read strobe to sprite memory.
REQ-011 mem_addr  output  ADDR_W  read address, valid while mem_rd is high.
REQ-012 mem_data  input  COLOR_W  read data, valid exactly one cycle after mem_rd.
REQ-013 out_valid  output  1  pixel available on out_x/out_y/out_color.
REQ-014 out_ready  input  1  downstream accepts pixel when high with out_valid.
REQ-015 out_x  output  8  base_x + column, modulo 256.
REQ-016 out_y  output  7  base_y + row, modulo 128.
REQ-017 out_color  output  COLOR_W  pixel colour.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  single-cycle pulse after the final pixel handshake.

Function
REQ-020 FSM states: IDLE, READ, DRAIN. IDLE->READ on start; READ->DRAIN on the cycle the last address (column 53, row 57) is issued; DRAIN->IDLE when the buffer is empty and no read is in flight, with done high during that transition cycle.
REQ-021 Accepted start: latch base_x/base_y, clear column/row counters to 0; start while busy is ignored and does not alter the latched bases.
REQ-022 Scan order: row-major; column increments 0..53; at column 53 column wraps to 0 and row increments; no address beyond row 57.
REQ-023 mem_addr = row*SPRITE_W + column, maintained incrementally (add 1 per issue); no multiplier.
REQ-024 Output buffer: 2 entries, FIFO order; mem_rd is asserted in READ only when (buffer occupancy + reads in flight) < 2.
REQ-025 Each returned mem_data is written to the buffer together with its column/row on the edge ending the data-valid cycle.
REQ-026 out_valid = buffer non-empty; entry pops on out_valid && out_ready; simultaneous push and pop keep occupancy unchanged.
REQ-027 out_x/out_y/out_color hold stable while out_valid is high and out_ready is low.
REQ-028 Latency: with out_ready held high, out_valid rises two rising edges after the edge sampling start; throughput one pixel per cycle thereafter; exactly 3132 handshakes per start.
REQ-029 done pulses on the cycle after the 3132nd handshake; busy falls on the same edge as done falls; new start accepted in the cycle done is high is ignored.
REQ-030 Screen coordinate sums wrap silently (no saturation, no clipping).

Reset
REQ-031 reset_n low: state IDLE, counters 0, buffer empty, in-flight read discarded; mem_rd, out_valid, busy, done 0; mem_addr, out_x, out_y, out_color 0.
REQ-032 Reset asserted mid-operation aborts the read with no done pulse; after release the block waits for a new start.

Structure
REQ-033 Shared package holds SPRITE_W, SPRITE_H, COLOR_W, ADDR_W defaults and the FSM state encoding.
REQ-034 The 2-entry buffer is a sub-module pika_pixel_skid (parameterised width, push/pop/full/empty).

Verification
REQ-035 Reset, start with base (10,20), out_ready=1, single-cycle memory returning addr[2:0] -> 3132 pixels, first (10,20,0), pixel 54 at (10,21), last (63,77); done one pulse; out_valid rises two edges after start.
REQ-036 Base (240,100) -> pixel column 20 row 30 at out_x=4, out_y=2 (wrapped); 3132 pixels total.
REQ-037 out_ready toggled randomly 50% -> sequence identical to REQ-035, no drop/duplicate, mem_rd never issued with occupancy+inflight=2, outputs stable while stalled.
REQ-038 start pulsed again at pixel 1000 with base (0,0) -> ignored; bases remain (10,20); single done.
REQ-039 reset_n low at pixel 500 with out_valid high -> all outputs 0 within the reset cycle, no done; subsequent start produces a full correct 3132-pixel read.
